// File: rtl/mem_port_arbiter_if.sv
// Bundle between the core array, the round-robin arbiter and the shared data memory.
// The slave modport is the arbiter side; the master modport is the cores plus memory.
interface mem_port_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
);
    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [NUM_CORES-1:0][1:0]        core_memcontrol;
    logic [NUM_CORES-1:0][ADDR_W-1:0] core_addr;
    logic [NUM_CORES-1:0][DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0][DATA_W-1:0] core_rdata;
    logic [NUM_CORES-1:0]             core_ack;
    logic [ADDR_W-1:0]                mem_addr;
    logic [DATA_W-1:0]                mem_wdata;
    logic                             mem_re;
    logic                             mem_we;
    logic [DATA_W-1:0]                mem_rdata;
    logic [GW-1:0]                    grant_id;
    logic                             busy;

    modport slave (
        input  core_memcontrol, core_addr, core_wdata, mem_rdata,
        output core_rdata, core_ack, mem_addr, mem_wdata, mem_re, mem_we, grant_id, busy
    );

    modport master (
        output core_memcontrol, core_addr, core_wdata, mem_rdata,
        input  core_rdata, core_ack, mem_addr, mem_wdata, mem_re, mem_we, grant_id, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising per-core read/write requests onto one data memory port.
// Each transaction walks IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> ACK.
module mem_port_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_LAT   = 1
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t                           state, state_nxt;
    logic [GW-1:0]                    last_grant, grant_q, pick_idx, cand;
    logic                             pick_vld;
    logic                             op_wr;
    logic [CW-1:0]                    cnt;
    logic [ADDR_W-1:0]                addr_q;
    logic [DATA_W-1:0]                wdata_q;
    logic [NUM_CORES-1:0][DATA_W-1:0] rdata_q;
    logic [NUM_CORES-1:0]             req;
    logic [NUM_CORES-1:0]             ack;

    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CORES) s = s - NUM_CORES;
        return GW'(s);
    endfunction

    // 11 is reserved and deliberately not treated as a request
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_req
        assign req[i] = (bus.core_memcontrol[i] == 2'b01) || (bus.core_memcontrol[i] == 2'b10);
    end

    // Scan farthest-to-nearest so the core closest after last_grant wins
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int off = NUM_CORES; off >= 1; off--) begin
            cand = wrap_idx(last_grant, off);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ack       = '0;
        unique case (state)
            IDLE:    if (pick_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = ACK;
            ACK: begin
                ack[grant_q] = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_CORES - 1);
            grant_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_wr      <= 1'b0;
            cnt        <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (pick_vld) begin
                    grant_q    <= pick_idx;
                    last_grant <= pick_idx;
                    addr_q     <= bus.core_addr[pick_idx];
                    wdata_q    <= bus.core_wdata[pick_idx];
                    op_wr      <= (bus.core_memcontrol[pick_idx] == 2'b10);
                end
                ISSUE: cnt <= CW'(MEM_LAT - 1);
                WAIT: begin
                    if (cnt == '0) begin
                        if (!op_wr) rdata_q[grant_q] <= bus.mem_rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_re     = (state == ISSUE) && !op_wr;
    assign bus.mem_we     = (state == ISSUE) && op_wr;
    assign bus.busy       = (state != IDLE);
    assign bus.core_ack   = ack;
    assign bus.core_rdata = rdata_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.grant_id   = grant_q;
endmodule
